wishbone_slave_mem: RTL

- Wishbone B4 responder: the slave end of the multi-slave Wishbone master, with a small byte-addressable register memory behind it.
- One instance per slave slot. It responds only to its own strobe bit, stb_i[SLAVE_ID].
- Supports classic cycles and CTI bursts (001 constant, 010 incrementing, 111 end).
- Produces registered ack_o/err_o and read data.

---
 rtl/wishbone_pkg.sv | 20 ++
 rtl/wishbone_slave_regfile.sv | 48 ++++
 rtl/wishbone_slave_mem.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone slave types: FSM state encoding and cycle-type identifiers.
package wishbone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } wb_slave_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // True when the master announces that another beat follows this one.
    function automatic logic cti_continues(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage

// File: rtl/wishbone_slave_regfile.sv
// Byte-enabled DEPTH x DATA_WIDTH word store with a registered, lane-masked read port.
module wishbone_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH      = 16,
    parameter int IDX_BITS   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [IDX_BITS-1:0]   word_idx,
    input  logic [SEL_WIDTH-1:0]  lane_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    genvar gi;
    for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{lane_sel[gi]}};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_reg[w] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[word_idx] <= (mem_reg[word_idx] & ~lane_mask) | (wr_data & lane_mask);
        end
    end

    // Output returns to zero whenever no read beat was taken, so data_o is clean outside acks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_en ? (mem_reg[word_idx] & lane_mask) : '0;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/wishbone_slave_mem.sv
// Wishbone B4 slave with a small register memory; classic and CTI bursts.
// Optional per-word tag bit enabled by defining WISHBONE_SLAVE_TAG_EN.
module wishbone_slave_mem
    import wishbone_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int                    DEPTH      = 16,
    parameter int                    SLAVE_ID   = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [1:0]            stb_i,
    input  logic                  cyc_i,
    input  logic [2:0]            cti_i,
    input  logic                  tag_add_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  tag_o,
    output logic [1:0]            state_o
);

    localparam int                    LANE_BITS = $clog2(SEL_WIDTH);
    localparam int                    IDX_BITS  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(DEPTH * SEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(SEL_WIDTH - 1);

    wb_slave_state_e       state_reg;
    logic                  ack_reg;
    logic                  err_reg;
    logic                  req;
    logic                  bad;
    logic                  take;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_BITS-1:0]   word_idx;

    assign req      = cyc_i & stb_i[SLAVE_ID];
    assign off      = addr_i - BASE_ADDR;
    // Offsets below BASE_ADDR wrap to huge values, so the range test also rejects them.
    assign bad      = (off >= SPAN) | ((off & LANE_MASK) != '0) | (sel_i == '0);
    assign word_idx = off[LANE_BITS +: IDX_BITS];

    always_comb begin
        take = 1'b0;
        case (state_reg)
            IDLE:    take = req;
            ACK:     take = req & cti_continues(cti_i);
            default: take = 1'b0;
        endcase
    end

    assign wr_en = take & ~bad & we_i;
    assign rd_en = take & ~bad & ~we_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ack_reg <= take & ~bad;
            err_reg <= take & bad;
            case (state_reg)
                IDLE: begin
                    if (req) state_reg <= ACK;
                end
                ACK: begin
                    if (!cyc_i)     state_reg <= IDLE;
                    else if (!take) state_reg <= WAIT;
                end
                WAIT: begin
                    // A strobe held past its ack parks here until released, preventing a second ack.
                    if (!cyc_i || !stb_i[SLAVE_ID]) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    wishbone_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_BITS   (IDX_BITS)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .word_idx (word_idx),
        .lane_sel (sel_i),
        .wr_data  (data_i),
        .rd_data  (data_o)
    );

`ifdef WISHBONE_SLAVE_TAG_EN
    logic [DEPTH-1:0] tag_mem_reg;
    logic             tag_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_mem_reg <= '0;
            tag_reg     <= 1'b0;
        end else begin
            if (wr_en) tag_mem_reg[word_idx] <= tag_add_i;
            tag_reg <= rd_en ? tag_mem_reg[word_idx] : 1'b0;
        end
    end

    assign tag_o = tag_reg;

    logic unused_inputs;
    assign unused_inputs = ^stb_i;
`else
    assign tag_o = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{stb_i, tag_add_i};
`endif

    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign state_o = state_reg;

endmodule
